// File: rtl/alu_share_arbiter_if.sv
// Bundle of requester, shared-ALU and response signals for alu_share_arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface alu_share_arbiter_if #(
  parameter int W   = 32,
  parameter int OPW = 4
);
  logic           req0_valid;
  logic [OPW-1:0] req0_op;
  logic [W-1:0]   req0_a;
  logic [W-1:0]   req0_b;
  logic           req0_ready;
  logic           req1_valid;
  logic [OPW-1:0] req1_op;
  logic [W-1:0]   req1_a;
  logic [W-1:0]   req1_b;
  logic           req1_ready;
  logic [OPW-1:0] alu_op;
  logic [W-1:0]   alu_operand1;
  logic [W-1:0]   alu_operand2;
  logic [W-1:0]   alu_result;
  logic           alu_zero;
  logic           rsp_valid;
  logic           rsp_id;
  logic [W-1:0]   rsp_result;
  logic           rsp_zero;
  logic           rsp_ready;
  logic [15:0]    grant_count0;
  logic [15:0]    grant_count1;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  alu_result, alu_zero, rsp_ready,
    output req0_ready, req1_ready,
    output alu_op, alu_operand1, alu_operand2,
    output rsp_valid, rsp_id, rsp_result, rsp_zero,
    output grant_count0, grant_count1
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output alu_result, alu_zero, rsp_ready,
    input  req0_ready, req1_ready,
    input  alu_op, alu_operand1, alu_operand2,
    input  rsp_valid, rsp_id, rsp_result, rsp_zero,
    input  grant_count0, grant_count1
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters,
// with a one-entry tagged response register drained by valid/ready.
module alu_share_arbiter #(
  parameter int W   = 32,
  parameter int OPW = 4
) (
  input  logic               clk,
  input  logic               rst,
  alu_share_arbiter_if.slave bus
);
  typedef enum logic [0:0] {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_e;

  state_e         state_q, state_d;
  logic           last_grant_q, last_grant_d;
  logic           rsp_id_q, rsp_id_d;
  logic [W-1:0]   rsp_result_q, rsp_result_d;
  logic           rsp_zero_q, rsp_zero_d;
  logic [15:0]    grant_count0_q, grant_count0_d;
  logic [15:0]    grant_count1_q, grant_count1_d;

  logic           can_issue_s;
  logic           winner_s;
  logic           ready0_s;
  logic           ready1_s;
  logic           issue_s;
  logic [OPW-1:0] alu_op_s;
  logic [W-1:0]   alu_operand1_s;
  logic [W-1:0]   alu_operand2_s;

  // Winner selection and per-requester readies; readies never depend on the ALU result
  always_comb begin
    can_issue_s = 1'b0;
    winner_s    = 1'b0;
    case (state_q)
      ST_EMPTY: can_issue_s = 1'b1;
      ST_FULL:  can_issue_s = bus.rsp_ready;
      default:  can_issue_s = 1'b0;
    endcase
    if (bus.req0_valid && bus.req1_valid) begin
      winner_s = ~last_grant_q;
    end else if (bus.req1_valid) begin
      winner_s = 1'b1;
    end else begin
      winner_s = 1'b0;
    end
    ready0_s = can_issue_s & ~rst & ~winner_s & bus.req0_valid;
    ready1_s = can_issue_s & ~rst & winner_s & bus.req1_valid;
    issue_s  = ready0_s | ready1_s;
  end

  // Steer the winner's op and operands to the shared ALU; idle drives an all-zero add
  always_comb begin
    alu_op_s       = {OPW{1'b0}};
    alu_operand1_s = {W{1'b0}};
    alu_operand2_s = {W{1'b0}};
    if (bus.req1_valid && winner_s) begin
      alu_op_s       = bus.req1_op;
      alu_operand1_s = bus.req1_a;
      alu_operand2_s = bus.req1_b;
    end else if (bus.req0_valid && !winner_s) begin
      alu_op_s       = bus.req0_op;
      alu_operand1_s = bus.req0_a;
      alu_operand2_s = bus.req0_b;
    end else begin
      alu_op_s       = {OPW{1'b0}};
      alu_operand1_s = {W{1'b0}};
      alu_operand2_s = {W{1'b0}};
    end
  end

  // Response register, round-robin pointer and saturating grant counters
  always_comb begin
    state_d        = state_q;
    last_grant_d   = last_grant_q;
    rsp_id_d       = rsp_id_q;
    rsp_result_d   = rsp_result_q;
    rsp_zero_d     = rsp_zero_q;
    grant_count0_d = grant_count0_q;
    grant_count1_d = grant_count1_q;
    if (issue_s) begin
      state_d      = ST_FULL;
      last_grant_d = winner_s;
      rsp_id_d     = winner_s;
      rsp_result_d = bus.alu_result;
      rsp_zero_d   = bus.alu_zero;
      if (winner_s) begin
        if (grant_count1_q != 16'hFFFF) begin
          grant_count1_d = grant_count1_q + 16'd1;
        end else begin
          grant_count1_d = grant_count1_q;
        end
      end else begin
        if (grant_count0_q != 16'hFFFF) begin
          grant_count0_d = grant_count0_q + 16'd1;
        end else begin
          grant_count0_d = grant_count0_q;
        end
      end
    end else if ((state_q == ST_FULL) && bus.rsp_ready) begin
      state_d = ST_EMPTY;
    end else begin
      state_d = state_q;
    end
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_EMPTY;
      last_grant_q   <= 1'b1;
      rsp_id_q       <= 1'b0;
      rsp_result_q   <= {W{1'b0}};
      rsp_zero_q     <= 1'b0;
      grant_count0_q <= 16'd0;
      grant_count1_q <= 16'd0;
    end else begin
      state_q        <= state_d;
      last_grant_q   <= last_grant_d;
      rsp_id_q       <= rsp_id_d;
      rsp_result_q   <= rsp_result_d;
      rsp_zero_q     <= rsp_zero_d;
      grant_count0_q <= grant_count0_d;
      grant_count1_q <= grant_count1_d;
    end
  end

  assign bus.req0_ready   = ready0_s;
  assign bus.req1_ready   = ready1_s;
  assign bus.alu_op       = alu_op_s;
  assign bus.alu_operand1 = alu_operand1_s;
  assign bus.alu_operand2 = alu_operand2_s;
  assign bus.rsp_valid    = (state_q == ST_FULL);
  assign bus.rsp_id       = rsp_id_q;
  assign bus.rsp_result   = rsp_result_q;
  assign bus.rsp_zero     = rsp_zero_q;
  assign bus.grant_count0 = grant_count0_q;
  assign bus.grant_count1 = grant_count1_q;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a small combinational ALU model
// standing in for the shared integer ALU.
module tb_alu_share_arbiter;
  logic clk;
  logic rst;
  int   checks;
  int   passes;

  alu_share_arbiter_if #(.W(32), .OPW(4)) bus ();

  alu_share_arbiter #(.W(32), .OPW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared ALU: 0 add, 1 sub, 2 and, 3 or, 4 xor, anything else adds
  function automatic logic [31:0] alu_model(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    case (op)
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      default: return a + b;
    endcase
  endfunction

  assign bus.alu_result = alu_model(bus.alu_op, bus.alu_operand1, bus.alu_operand2);
  assign bus.alu_zero   = (bus.alu_result == 32'd0);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req0(input logic v, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b);
    bus.req0_valid = v; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
  endtask

  task automatic set_req1(input logic v, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b);
    bus.req1_valid = v; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
  endtask

  task automatic apply_reset();
    set_req0(1'b0, 4'd0, 32'd0, 32'd0);
    set_req1(1'b0, 4'd0, 32'd0, 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.rsp_ready = 1'b0;
    set_req0(1'b1, 4'd0, 32'd1, 32'd1);
    set_req1(1'b1, 4'd0, 32'd2, 32'd2);
    tick();
    tick();
    checks++; if (bus.req0_ready !== 1'b0) $display("FAIL reset_ready0 got %0h exp 0", bus.req0_ready); else passes++;
    checks++; if (bus.req1_ready !== 1'b0) $display("FAIL reset_ready1 got %0h exp 0", bus.req1_ready); else passes++;
    checks++; if (bus.rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got %0h exp 0", bus.rsp_valid); else passes++;
    checks++; if (bus.rsp_id !== 1'b0) $display("FAIL reset_rsp_id got %0h exp 0", bus.rsp_id); else passes++;
    checks++; if (bus.rsp_result !== 32'd0) $display("FAIL reset_rsp_result got %0h exp 0", bus.rsp_result); else passes++;
    checks++; if (bus.rsp_zero !== 1'b0) $display("FAIL reset_rsp_zero got %0h exp 0", bus.rsp_zero); else passes++;
    checks++; if (bus.grant_count0 !== 16'd0) $display("FAIL reset_count0 got %0h exp 0", bus.grant_count0); else passes++;
    checks++; if (bus.grant_count1 !== 16'd0) $display("FAIL reset_count1 got %0h exp 0", bus.grant_count1); else passes++;
    set_req0(1'b0, 4'd0, 32'd0, 32'd0);
    set_req1(1'b0, 4'd0, 32'd0, 32'd0);
    rst = 1'b0;
  endtask

  task automatic test_single_op();
    bus.rsp_ready = 1'b1;
    set_req0(1'b1, 4'd0, 32'd5, 32'd7);
    #1;
    checks++; if (bus.req0_ready !== 1'b1) $display("FAIL single_ready0 got %0h exp 1", bus.req0_ready); else passes++;
    checks++; if (bus.alu_operand1 !== 32'd5) $display("FAIL single_alu_a got %0h exp 5", bus.alu_operand1); else passes++;
    checks++; if (bus.alu_operand2 !== 32'd7) $display("FAIL single_alu_b got %0h exp 7", bus.alu_operand2); else passes++;
    tick();
    set_req0(1'b0, 4'd0, 32'd0, 32'd0);
    #1;
    checks++; if (bus.rsp_valid !== 1'b1) $display("FAIL single_rsp_valid got %0h exp 1", bus.rsp_valid); else passes++;
    checks++; if (bus.rsp_id !== 1'b0) $display("FAIL single_rsp_id got %0h exp 0", bus.rsp_id); else passes++;
    checks++; if (bus.rsp_result !== 32'd12) $display("FAIL single_rsp_result got %0h exp c", bus.rsp_result); else passes++;
    checks++; if (bus.rsp_zero !== 1'b0) $display("FAIL single_rsp_zero got %0h exp 0", bus.rsp_zero); else passes++;
    checks++; if (bus.grant_count0 !== 16'd1) $display("FAIL single_count0 got %0h exp 1", bus.grant_count0); else passes++;
  endtask

  task automatic test_drain();
    checks++; if (bus.alu_op !== 4'd0) $display("FAIL drain_idle_op got %0h exp 0", bus.alu_op); else passes++;
    checks++; if (bus.alu_operand1 !== 32'd0) $display("FAIL drain_idle_a got %0h exp 0", bus.alu_operand1); else passes++;
    checks++; if (bus.alu_operand2 !== 32'd0) $display("FAIL drain_idle_b got %0h exp 0", bus.alu_operand2); else passes++;
    tick();
    checks++; if (bus.rsp_valid !== 1'b0) $display("FAIL drain_rsp_valid got %0h exp 0", bus.rsp_valid); else passes++;
  endtask

  task automatic test_contention();
    logic exp_id;
    apply_reset();
    bus.rsp_ready = 1'b1;
    set_req0(1'b1, 4'd1, 32'd9, 32'd9);
    set_req1(1'b1, 4'd4, 32'h0000_00F0, 32'h0000_000F);
    for (int i = 0; i < 4; i++) begin
      exp_id = (i % 2 == 1);
      #1;
      checks++; if (bus.req0_ready !== !exp_id) $display("FAIL contend_ready0[%0d] got %0h exp %0h", i, bus.req0_ready, !exp_id); else passes++;
      checks++; if (bus.req1_ready !== exp_id) $display("FAIL contend_ready1[%0d] got %0h exp %0h", i, bus.req1_ready, exp_id); else passes++;
      tick();
      checks++; if (bus.rsp_id !== exp_id) $display("FAIL contend_id[%0d] got %0h exp %0h", i, bus.rsp_id, exp_id); else passes++;
      checks++; if (bus.rsp_result !== (exp_id ? 32'h0000_00FF : 32'd0)) $display("FAIL contend_result[%0d] got %0h exp %0h", i, bus.rsp_result, (exp_id ? 32'h0000_00FF : 32'd0)); else passes++;
      checks++; if (bus.rsp_zero !== !exp_id) $display("FAIL contend_zero[%0d] got %0h exp %0h", i, bus.rsp_zero, !exp_id); else passes++;
    end
    set_req0(1'b0, 4'd0, 32'd0, 32'd0);
    set_req1(1'b0, 4'd0, 32'd0, 32'd0);
    checks++; if (bus.grant_count0 !== 16'd2) $display("FAIL contend_count0 got %0h exp 2", bus.grant_count0); else passes++;
    checks++; if (bus.grant_count1 !== 16'd2) $display("FAIL contend_count1 got %0h exp 2", bus.grant_count1); else passes++;
    tick();
  endtask

  task automatic test_backpressure();
    bus.rsp_ready = 1'b1;
    set_req0(1'b1, 4'd0, 32'd3, 32'd4);
    tick();
    set_req0(1'b0, 4'd0, 32'd0, 32'd0);
    bus.rsp_ready = 1'b0;
    set_req1(1'b1, 4'd2, 32'h0000_FF00, 32'h0000_0FF0);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (bus.req1_ready !== 1'b0) $display("FAIL bp_ready1[%0d] got %0h exp 0", i, bus.req1_ready); else passes++;
      checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 1'b0 || bus.rsp_result !== 32'd7) $display("FAIL bp_hold[%0d] got v%0h id%0h r%0h exp v1 id0 r7", i, bus.rsp_valid, bus.rsp_id, bus.rsp_result); else passes++;
      tick();
    end
    bus.rsp_ready = 1'b1;
    #1;
    checks++; if (bus.req1_ready !== 1'b1) $display("FAIL bp_release_ready1 got %0h exp 1", bus.req1_ready); else passes++;
    tick();
    set_req1(1'b0, 4'd0, 32'd0, 32'd0);
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 1'b1) $display("FAIL bp_new_rsp got v%0h id%0h exp v1 id1", bus.rsp_valid, bus.rsp_id); else passes++;
    checks++; if (bus.rsp_result !== 32'h0000_0F00) $display("FAIL bp_new_result got %0h exp f00", bus.rsp_result); else passes++;
    checks++; if (bus.grant_count0 !== 16'd3 || bus.grant_count1 !== 16'd3) $display("FAIL bp_counts got %0h/%0h exp 3/3", bus.grant_count0, bus.grant_count1); else passes++;
    tick();
  endtask

  task automatic test_reset_mid();
    bus.rsp_ready = 1'b0;
    set_req0(1'b1, 4'd0, 32'd1, 32'd1);
    tick();
    set_req0(1'b0, 4'd0, 32'd0, 32'd0);
    checks++; if (bus.rsp_valid !== 1'b1) $display("FAIL midrst_full got %0h exp 1", bus.rsp_valid); else passes++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (bus.rsp_valid !== 1'b0) $display("FAIL midrst_rsp_valid got %0h exp 0", bus.rsp_valid); else passes++;
    checks++; if (bus.rsp_result !== 32'd0) $display("FAIL midrst_rsp_result got %0h exp 0", bus.rsp_result); else passes++;
    checks++; if (bus.grant_count0 !== 16'd0 || bus.grant_count1 !== 16'd0) $display("FAIL midrst_counts got %0h/%0h exp 0/0", bus.grant_count0, bus.grant_count1); else passes++;
    bus.rsp_ready = 1'b1;
    set_req0(1'b1, 4'd0, 32'd1, 32'd2);
    set_req1(1'b1, 4'd0, 32'd10, 32'd20);
    #1;
    checks++; if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) $display("FAIL midrst_first_grant got r0=%0h r1=%0h exp r0=1 r1=0", bus.req0_ready, bus.req1_ready); else passes++;
    tick();
    set_req0(1'b0, 4'd0, 32'd0, 32'd0);
    set_req1(1'b0, 4'd0, 32'd0, 32'd0);
    checks++; if (bus.rsp_id !== 1'b0 || bus.rsp_result !== 32'd3) $display("FAIL midrst_rsp got id%0h r%0h exp id0 r3", bus.rsp_id, bus.rsp_result); else passes++;
    tick();
  endtask

  task automatic test_saturation();
    force dut.grant_count1_q = 16'hFFFE;
    tick();
    release dut.grant_count1_q;
    #1;
    checks++; if (bus.grant_count1 !== 16'hFFFE) $display("FAIL sat_preload got %0h exp fffe", bus.grant_count1); else passes++;
    bus.rsp_ready = 1'b1;
    set_req1(1'b1, 4'd0, 32'd0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (bus.grant_count1 !== 16'hFFFF) $display("FAIL sat_count1[%0d] got %0h exp ffff", i, bus.grant_count1); else passes++;
    end
    set_req1(1'b0, 4'd0, 32'd0, 32'd0);
    checks++; if (bus.rsp_zero !== 1'b1 || bus.rsp_id !== 1'b1) $display("FAIL sat_rsp got z%0h id%0h exp z1 id1", bus.rsp_zero, bus.rsp_id); else passes++;
    tick();
  endtask

  initial begin
    checks = 0;
    passes = 0;
    rst = 1'b1;
    bus.rsp_ready = 1'b0;
    set_req0(1'b0, 4'd0, 32'd0, 32'd0);
    set_req1(1'b0, 4'd0, 32'd0, 32'd0);
    test_reset();
    test_single_op();
    test_drain();
    test_contention();
    test_backpressure();
    test_reset_mid();
    test_saturation();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Round-robin arbiter that time-shares the single integer ALU between two requesters, such as the execute stage and a branch/address helper. Each request carries an ALU op and two operands. The block drives the shared ALU's `op`/`operand1`/`operand2` inputs and captures `result`/`zero` into a one-entry response register. That register is tagged with the requester ID and is drained under a valid/ready handshake.

## Interface
Parameters:
- `W`, 32: operand/result width; must match the ALU.
- `OPW`, 4: ALU op width.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `req0_valid`  in  1  requester 0 has an operation.
- `req0_op`  in  OPW  requester 0 ALU op code.
- `req0_a`, `req0_b`  in  W  requester 0 operands.
- `req0_ready`  out  1  requester 0 op accepted this cycle.
- `req1_valid`, `req1_op`, `req1_a`, `req1_b`, `req1_ready`: same as requester 0, for requester 1.
- `alu_op`  out  OPW  to shared ALU `op`.
- `alu_operand1`, `alu_operand2`  out  W  to shared ALU.
- `alu_result`  in  W  from shared ALU (combinational).
- `alu_zero`  in  1  from shared ALU.
- `rsp_valid`  out  1  response register holds a result.
- `rsp_id`  out  1  requester that issued the held result.
- `rsp_result`  out  W  held result.
- `rsp_zero`  out  1  held zero flag.
- `rsp_ready`  in  1  consumer takes the response this cycle.
- `grant_count0`, `grant_count1`  out  16  accepted-op counters per requester; saturate at 0xFFFF.

## Operation
- **State machine:**
  - EMPTY: response register invalid.
  - FULL: response register valid.
- **can_issue** = (state==EMPTY) | (state==FULL & rsp_ready).
- **Arbitration (combinational):**
  - If only one requester is valid, it wins.
  - If both are valid, the winner is the requester not equal to `last_grant`.
  - `reqN_ready` = can_issue & winner==N & reqN_valid.
  - At most one ready is high per cycle.
- **ALU drive:**
  - The `alu_*` outputs carry the winner's op/operands whenever any request is valid.
  - When no request is valid, they carry all-zero (op 0000 = add, operands 0).
- **Issue** (any ready high):
  - Capture `alu_result`, `alu_zero` and the winner ID into the response register.
  - Set `last_grant` to the winner.
  - Increment that requester's grant counter unless it is 0xFFFF.
  - Next state is FULL.
- **Drain without issue:**
  - FULL & rsp_ready & no issue goes to EMPTY.
- **Stall:**
  - FULL & !rsp_ready holds all response outputs stable and forces both readies low.
  - Requesters must hold valid/op/operands stable until ready.
- **Decoding:** op codes are not interpreted. Any 4-bit value passes through, and unsupported ops yield whatever the ALU returns (its add default).
- **Reset:**
  - state=EMPTY, `rsp_valid`=0, `rsp_id`=0, `rsp_result`=0, `rsp_zero`=0.
  - `last_grant`=1, so requester 0 wins the first conflict.
  - Both counters are 0.
  - Readies are 0 during the reset cycle.
  - Reset asserted mid-operation discards the held response without a handshake.

## Timing
- Accept-to-response latency is 1 cycle: an op accepted in cycle N appears on `rsp_*` with `rsp_valid`=1 in cycle N+1.
- Throughput is 1 op/cycle while `rsp_ready`=1, including simultaneous drain and issue in FULL.
- Ready is a combinational function of valid, state, `rsp_ready` and `last_grant`. It has no path from `alu_result`.
- The ALU is combinational. The critical path is winner mux → ALU → response register.
- Under continuous contention, grants strictly alternate 0,1,0,1. Maximum wait is 1 accepted op of the other requester, plus any consumer stall.
- Counters update in the same edge as the capture.

## Test plan
- **Reset then single op:**
  - Stimulus: after reset, req0 op=0000 a=5 b=7.
  - Required: `req0_ready`=1 same cycle; next cycle `rsp_valid`=1, id=0, result=12, zero=0; `grant_count0`=1.
- **Contention alternation:**
  - Stimulus: both requesters valid for 4 cycles, `rsp_ready`=1. req0 is sub 9-9; req1 is xor 0xF0^0x0F.
  - Required: responses in order id 0 (0, zero=1), 1 (0xFF), 0, 1; each counter ends at 2.
- **Backpressure:**
  - Stimulus: `rsp_ready`=0 after one accepted op, req1 valid for 3 cycles.
  - Required: `rsp_*` held constant; `req1_ready`=0 throughout.
  - When `rsp_ready` rises, the old response drains and req1 is accepted the same cycle; its result appears next cycle.
- **Drain to EMPTY:**
  - Stimulus: one op, then no valids, `rsp_ready`=1.
  - Required: `rsp_valid` falls the cycle after the drain; `alu_*` outputs are zero while idle.
- **Reset mid-operation:**
  - Stimulus: FULL with `rsp_ready`=0; assert `rst` one cycle.
  - Required: next cycle `rsp_valid`=0, counters 0; a subsequent conflict grants requester 0 first.
- **Counter saturation:**
  - Stimulus: force `grant_count1` to 0xFFFE and issue 3 req1 ops.
  - Required: the counter reads 0xFFFF and stays there.
